// File: rtl/move_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : move_sequencer_pkg                                       |
// | Purpose : Shared types and constants for the move sequencer and    |
// |           the X/Y position tracker it drives.                      |
// | Contents: direction bit indices, coordinate type, FSM state enum,  |
// |           one-hot direction helper.                                |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package move_sequencer_pkg;

   // Bit positions on the dir_udlr bus.
   localparam int DIR_RIGHT = 3;   // x + 1
   localparam int DIR_LEFT  = 2;   // x - 1
   localparam int DIR_DOWN  = 1;   // y - 1
   localparam int DIR_UP    = 0;   // y + 1

   // 8-bit grid coordinate, wraps modulo 256; shared with the tracker.
   typedef logic [7:0] coord_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } move_state_t;

   // One-hot dir_udlr pattern for a single direction bit index.
   function automatic logic [3:0] dir_onehot(input int idx);
      return 4'b0001 << idx;
   endfunction

endpackage : move_sequencer_pkg
`default_nettype wire

// File: rtl/axis_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : axis_step                                                |
// | Purpose : Decides whether one axis still needs to move and which   |
// |           way the shortest wrap-around path goes.                  |
// | Ports   : cur      in  current coordinate                          |
// |           target   in  commanded coordinate                        |
// |           active   out axis not yet at target                      |
// |           positive out step +1 (RIGHT/UP) when set, -1 otherwise   |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module axis_step
   import move_sequencer_pkg::*;
(
   input  coord_t cur,
   input  coord_t target,
   output logic   active,
   output logic   positive
);

   // Distance travelling in the + direction, modulo 256.
   coord_t w_delta;

   assign w_delta  = target - cur;
   assign active   = (w_delta != 8'd0);
   // 1..128 is shorter (or tied at 128) going +; 129..255 is shorter going -.
   assign positive = active && (w_delta <= 8'd128);

endmodule : axis_step
`default_nettype wire

// File: rtl/move_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : move_sequencer                                           |
// | Purpose : Walks an edge-triggered X/Y tracker to a commanded       |
// |           target, one grid step per STEP_DIV cycles, via the       |
// |           shortest wrap-around path (X first, then Y).             |
// | Ports   : clk, rst_n        clock, async active-low reset          |
// |           cmd_valid/ready   target handshake (ready only in IDLE)  |
// |           cmd_x, cmd_y      target, sampled on handshake           |
// |           abort             end current move after this edge       |
// |           dir_udlr          one-hot registered step pulses         |
// |           busy, done        move in progress / one-cycle finish    |
// |           cur_x, cur_y      shadow of the tracker position         |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module move_sequencer
   import move_sequencer_pkg::*;
#(
   parameter int STEP_DIV = 4          // cycles per step, 2..255
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  coord_t     cmd_x,
   input  coord_t     cmd_y,
   input  logic       abort,
   output logic [3:0] dir_udlr,
   output logic       busy,
   output logic       done,
   output coord_t     cur_x,
   output coord_t     cur_y
);

   // GAP ends when the counter (cleared on PULSE exit) reaches this value,
   // giving STEP_DIV-1 low cycles.
   localparam logic [7:0] c_GAP_LAST = 8'(STEP_DIV - 2);

   move_state_t r_state, w_state_nxt;
   coord_t      r_cur_x, r_cur_y, w_cur_x_nxt, w_cur_y_nxt;
   coord_t      r_tgt_x, r_tgt_y, w_tgt_x_nxt, w_tgt_y_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic [3:0]  r_dir, w_dir_nxt;
   logic        r_done, w_done_nxt;

   logic        w_accept;
   coord_t      w_sel_tgt_x, w_sel_tgt_y;
   logic        w_x_active, w_x_pos, w_y_active, w_y_pos;
   logic        w_more;
   logic [3:0]  w_step_dir;

   assign w_accept = cmd_valid && (r_state == IDLE);

   // In IDLE the first step is decided straight from the incoming command;
   // afterwards from the latched target.
   assign w_sel_tgt_x = (r_state == IDLE) ? cmd_x : r_tgt_x;
   assign w_sel_tgt_y = (r_state == IDLE) ? cmd_y : r_tgt_y;

   axis_step u_axis_x (
      .cur      (r_cur_x),
      .target   (w_sel_tgt_x),
      .active   (w_x_active),
      .positive (w_x_pos)
   );

   axis_step u_axis_y (
      .cur      (r_cur_y),
      .target   (w_sel_tgt_y),
      .active   (w_y_active),
      .positive (w_y_pos)
   );

   assign w_more = w_x_active || w_y_active;

   // X finishes completely before Y starts; exactly one bit ever set.
   always_comb begin
      w_step_dir = 4'b0000;
      if (w_x_active) begin
         w_step_dir = w_x_pos ? dir_onehot(DIR_RIGHT) : dir_onehot(DIR_LEFT);
      end else if (w_y_active) begin
         w_step_dir = w_y_pos ? dir_onehot(DIR_UP) : dir_onehot(DIR_DOWN);
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cur_x_nxt = r_cur_x;
      w_cur_y_nxt = r_cur_y;
      w_tgt_x_nxt = r_tgt_x;
      w_tgt_y_nxt = r_tgt_y;
      w_cnt_nxt   = r_cnt;
      w_dir_nxt   = 4'b0000;
      w_done_nxt  = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_tgt_x_nxt = cmd_x;
               w_tgt_y_nxt = cmd_y;
               if (w_more) begin
                  w_state_nxt = PULSE;
                  w_dir_nxt   = w_step_dir;
               end else begin
                  w_done_nxt  = 1'b1;
               end
            end
         end

         PULSE: begin
            // The tracker steps on this same edge, so the shadow always
            // commits the step, even when aborting.
            if (r_dir[DIR_RIGHT]) w_cur_x_nxt = r_cur_x + 8'd1;
            if (r_dir[DIR_LEFT])  w_cur_x_nxt = r_cur_x - 8'd1;
            if (r_dir[DIR_UP])    w_cur_y_nxt = r_cur_y + 8'd1;
            if (r_dir[DIR_DOWN])  w_cur_y_nxt = r_cur_y - 8'd1;
            w_cnt_nxt = 8'd0;
            if (abort) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = GAP;
            end
         end

         GAP: begin
            if (abort) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end else if (r_cnt == c_GAP_LAST) begin
               if (w_more) begin
                  w_state_nxt = PULSE;
                  w_dir_nxt   = w_step_dir;
               end else begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_x <= 8'd0;
         r_cur_y <= 8'd0;
         r_tgt_x <= 8'd0;
         r_tgt_y <= 8'd0;
         r_cnt   <= 8'd0;
         r_dir   <= 4'b0000;
         r_done  <= 1'b0;
      end else begin
         r_cur_x <= w_cur_x_nxt;
         r_cur_y <= w_cur_y_nxt;
         r_tgt_x <= w_tgt_x_nxt;
         r_tgt_y <= w_tgt_y_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dir   <= w_dir_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign cmd_ready = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign dir_udlr  = r_dir;
   assign done      = r_done;
   assign cur_x     = r_cur_x;
   assign cur_y     = r_cur_y;

endmodule : move_sequencer
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_move_sequencer                                        |
// | Purpose : Self-checking bench for move_sequencer: directed moves   |
// |           plus randomized targets/aborts against a path model and  |
// |           an edge-triggered tracker model.                         |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_move_sequencer;

   localparam int c_SD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_x = 8'd0;
   logic [7:0] cmd_y = 8'd0;
   logic       abort = 1'b0;
   logic [3:0] dir_udlr;
   logic       busy;
   logic       done;
   logic [7:0] cur_x;
   logic [7:0] cur_y;

   int n_checks = 0;
   int n_fail   = 0;
   int mx = 0;            // model position
   int my = 0;

   move_sequencer #(.STEP_DIV(c_SD)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_x     (cmd_x),
      .cmd_y     (cmd_y),
      .abort     (abort),
      .dir_udlr  (dir_udlr),
      .busy      (busy),
      .done      (done),
      .cur_x     (cur_x),
      .cur_y     (cur_y)
   );

   always #5 clk = ~clk;

   // Edge-triggered tracker: acts on rising edges of the direction bits,
   // RIGHT > LEFT > DOWN > UP priority.
   logic [7:0] trk_x, trk_y;
   logic [3:0] trk_prev;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trk_x    <= 8'd0;
         trk_y    <= 8'd0;
         trk_prev <= 4'd0;
      end else begin
         trk_prev <= dir_udlr;
         if      (dir_udlr[3] && !trk_prev[3]) trk_x <= trk_x + 8'd1;
         else if (dir_udlr[2] && !trk_prev[2]) trk_x <= trk_x - 8'd1;
         else if (dir_udlr[1] && !trk_prev[1]) trk_y <= trk_y - 8'd1;
         else if (dir_udlr[0] && !trk_prev[0]) trk_y <= trk_y + 8'd1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Issues a command at the current negedge (DUT must be idle) and checks
   // every cycle up to and including the done cycle. abort_at < 0: no abort.
   task automatic run_move(input int tx, input int ty, input int abort_at);
      int         dirs[$];
      int         dx, dy, n_steps, last, nat_last;
      logic [3:0] ed;
      logic [6:0] exp_o;
      logic [15:0] pos;
      dx = ((tx - mx) % 256 + 256) % 256;
      dy = ((ty - my) % 256 + 256) % 256;
      if (dx >= 1 && dx <= 128) repeat (dx)       dirs.push_back(8);
      else if (dx > 128)        repeat (256 - dx) dirs.push_back(4);
      if (dy >= 1 && dy <= 128) repeat (dy)       dirs.push_back(1);
      else if (dy > 128)        repeat (256 - dy) dirs.push_back(2);
      n_steps  = dirs.size();
      nat_last = n_steps * c_SD;
      last     = nat_last;
      if (abort_at >= 0 && abort_at < nat_last) last = abort_at + 1;

      cmd_x     = tx[7:0];
      cmd_y     = ty[7:0];
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;

      for (int k = 0; k <= last; k++) begin
         ed = 4'd0;
         if (k < last && (k % c_SD) == 0 && (k / c_SD) < n_steps)
            ed = dirs[k / c_SD][3:0];
         exp_o = {ed, (k == last), (k < last), (k >= last)};
         check($sformatf("outs(t=%0d,%0d k=%0d)", tx, ty, k),
               {25'd0, dir_udlr, done, busy, cmd_ready}, {25'd0, exp_o});
         pos = {mx[7:0], my[7:0]};
         check($sformatf("cur(k=%0d)", k), {16'd0, cur_x, cur_y}, {16'd0, pos});
         if (ed == 4'd8) mx = (mx + 1) % 256;
         if (ed == 4'd4) mx = (mx + 255) % 256;
         if (ed == 4'd1) my = (my + 1) % 256;
         if (ed == 4'd2) my = (my + 255) % 256;
         abort = (abort_at >= 0 && abort_at < nat_last && k == abort_at);
         if (k < last) @(negedge clk);
      end
      abort = 1'b0;
      pos = {mx[7:0], my[7:0]};
      check("tracker", {16'd0, trk_x, trk_y}, {16'd0, pos});
   endtask

   initial begin
      int tx, ty, ab;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset", {16'd0, dir_udlr, done, busy, cmd_ready, cur_x, cur_y},
            {16'd0, 4'd0, 1'b0, 1'b0, 1'b1, 16'd0});
      rst_n = 1'b1;
      @(negedge clk);

      run_move(3, 0, -1);
      run_move(250, 0, -1);
      run_move(0, 0, -1);
      run_move(128, 5, -1);
      run_move(2, 2, -1);
      run_move(2, 2, -1);          // zero-step move
      run_move(0, 0, -1);
      run_move(0, 200, 9);         // abort in GAP after third DOWN pulse
      check("abort pos", {16'd0, cur_x, cur_y}, {16'd0, 8'd0, 8'd253});
      run_move(0, 0, -1);

      // Asynchronous reset in the middle of a move.
      cmd_x = 8'd10; cmd_y = 8'd0; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async rst", {16'd0, dir_udlr, done, busy, cmd_ready, cur_x, cur_y},
            {16'd0, 4'd0, 1'b0, 1'b0, 1'b1, 16'd0});
      mx = 0; my = 0;
      @(negedge clk);
      rst_n = 1'b1;
      run_move(1, 1, -1);

      // Randomized targets with occasional aborts and zero-step moves.
      for (int i = 0; i < 16; i++) begin
         tx = $urandom_range(0, 255);
         ty = $urandom_range(0, 255);
         if ($urandom_range(0, 5) == 0) begin tx = mx; ty = my; end
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
         run_move(tx, ty, ab);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_move_sequencer
`default_nettype wire
